// File: rtl/half_adder_a_pkg.sv
// Shared defaults and helpers for the half_adder_a block.
`timescale 1ns/1ps
package half_adder_a_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  // All-ones value of a cnt_w-bit counter, i.e. its saturation point.
  function automatic longint unsigned CNT_MAX(input int cnt_w);
    return (64'd1 << cnt_w) - 64'd1;
  endfunction

endpackage

// File: rtl/half_adder_a_if.sv
// Signal bundle for one half_adder_a instance; master drives operands, slave returns results.
// Macro HALF_ADDER_A_STATS_EN adds the carry-event count.
`timescale 1ns/1ps
interface half_adder_a_if
  import half_adder_a_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y1;
  logic [WIDTH-1:0] y2;
  logic             v_in;
  logic [WIDTH-1:0] y1_q;
  logic [WIDTH-1:0] y2_q;
  logic             v_q;
`ifdef HALF_ADDER_A_STATS_EN
  logic [CNT_W-1:0] carry_cnt;
`endif

  modport master (
    output a, b, v_in,
    input  y1, y2, y1_q, y2_q, v_q
`ifdef HALF_ADDER_A_STATS_EN
    , input carry_cnt
`endif
  );

  modport slave (
    input  a, b, v_in,
    output y1, y2, y1_q, y2_q, v_q
`ifdef HALF_ADDER_A_STATS_EN
    , output carry_cnt
`endif
  );

endinterface

// File: rtl/half_adder_a_cell.sv
// Single-lane half adder: s = a ^ b, c = a & b.
// Purely combinational, zero latency, no backpressure.
`timescale 1ns/1ps
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/half_adder_a.sv
// WIDTH-lane half adder with combinational outputs plus a 1-cycle registered copy and valid.
// Macro HALF_ADDER_A_STATS_EN adds a saturating carry-event counter (carry_cnt).
`timescale 1ns/1ps
module half_adder_a
  import half_adder_a_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  input  logic             clk,
  input  logic             rst,
  input  logic             v_in,
  output logic [WIDTH-1:0] y1_q,
  output logic [WIDTH-1:0] y2_q,
  output logic             v_q
`ifdef HALF_ADDER_A_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("half_adder_a: WIDTH and CNT_W must both be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (
      .a (a[i]),
      .b (b[i]),
      .s (y1[i]),
      .c (y2[i])
    );
  end

  // Data holds when v_in is low; only the valid bit follows v_in every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      y1_q <= '0;
      y2_q <= '0;
      v_q  <= 1'b0;
    end else begin
      v_q <= v_in;
      if (v_in) begin
        y1_q <= y1;
        y2_q <= y2;
      end
    end
  end

`ifdef HALF_ADDER_A_STATS_EN
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX(CNT_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (v_in && (|y2) && (carry_cnt != CNT_SAT)) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_half_adder_a.sv
// Scoreboard bench for half_adder_a: comb lanes, full-adder chain, WIDTH=4, register stage.
`timescale 1ns/1ps
module tb_half_adder_a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  // Main WIDTH=1 instance through the interface
  half_adder_a_if #(.WIDTH(1), .CNT_W(2)) bus ();

  half_adder_a #(.WIDTH(1), .CNT_W(2)) u_dut (
    .a(bus.a), .b(bus.b), .y1(bus.y1), .y2(bus.y2),
    .clk(clk), .rst(rst), .v_in(bus.v_in),
    .y1_q(bus.y1_q), .y2_q(bus.y2_q), .v_q(bus.v_q)
`ifdef HALF_ADDER_A_STATS_EN
    , .carry_cnt(bus.carry_cnt)
`endif
  );

  // Full adder from two half adders plus an OR
  logic fa = 1'b0, fb = 1'b0, fc = 1'b0;
  logic fs1, fc1, fsum, fc2, fcout;
  logic dx1, dx2, dxv, dy1, dy2, dyv;
`ifdef HALF_ADDER_A_STATS_EN
  logic [15:0] dxc, dyc;
`endif

  half_adder_a ha_x (
    .a(fa), .b(fb), .y1(fs1), .y2(fc1),
    .clk(clk), .rst(rst), .v_in(1'b0),
    .y1_q(dx1), .y2_q(dx2), .v_q(dxv)
`ifdef HALF_ADDER_A_STATS_EN
    , .carry_cnt(dxc)
`endif
  );

  half_adder_a ha_y (
    .a(fs1), .b(fc), .y1(fsum), .y2(fc2),
    .clk(clk), .rst(rst), .v_in(1'b0),
    .y1_q(dy1), .y2_q(dy2), .v_q(dyv)
`ifdef HALF_ADDER_A_STATS_EN
    , .carry_cnt(dyc)
`endif
  );

  assign fcout = fc1 | fc2;

  // WIDTH=4 instance
  logic [3:0] a4 = '0, b4 = '0;
  logic [3:0] s4, c4, q1_4, q2_4;
  logic       qv4;
`ifdef HALF_ADDER_A_STATS_EN
  logic [15:0] cnt4;
`endif

  half_adder_a #(.WIDTH(4)) u_w4 (
    .a(a4), .b(b4), .y1(s4), .y2(c4),
    .clk(clk), .rst(rst), .v_in(1'b0),
    .y1_q(q1_4), .y2_q(q2_4), .v_q(qv4)
`ifdef HALF_ADDER_A_STATS_EN
    , .carry_cnt(cnt4)
`endif
  );

  // Scoreboards
  typedef struct {
    int         kind;   // 0: w1 lane, 1: full adder, 2: width 4
    logic [3:0] e1;
    logic [3:0] e2;
    string      nm;
  } comb_t;

  typedef struct {
    logic  e1;
    logic  e2;
    string nm;
  } reg_t;

  comb_t comb_q[$];
  reg_t  reg_q[$];
  event  comb_evt;

  initial begin
    comb_t c;
    forever begin
      @(comb_evt);
      while (comb_q.size() > 0) begin
        c = comb_q.pop_front();
        case (c.kind)
          0:       chk(c.nm, 16'({bus.y2, bus.y1}), 16'({c.e2[0], c.e1[0]}));
          1:       chk(c.nm, 16'({fcout, fsum}), 16'({c.e2[0], c.e1[0]}));
          default: chk(c.nm, 16'({c4, s4}), 16'({c.e2, c.e1}));
        endcase
      end
    end
  end

  reg_t r;
  always @(negedge clk) begin
    if (bus.v_q === 1'b1) begin
      if (reg_q.size() == 0) begin
        chk("unexpected_v_q", 16'd1, 16'd0);
      end else begin
        r = reg_q.pop_front();
        chk(r.nm, 16'({bus.y2_q, bus.y1_q}), 16'({r.e2, r.e1}));
      end
    end
  end

  // Stimulus helpers
  task automatic comb_vec(input int kind, input logic [3:0] x, input logic [3:0] y,
                          input logic z, input logic [3:0] e1, input logic [3:0] e2,
                          input string nm);
    case (kind)
      0: begin bus.a = x[0]; bus.b = y[0]; end
      1: begin fa = x[0]; fb = y[0]; fc = z; end
      default: begin a4 = x; b4 = y; end
    endcase
    comb_q.push_back('{kind, e1, e2, nm});
    #1 -> comb_evt;
    #99;
  endtask

  // Starts at a negedge; drives just after it and returns at the next negedge.
  task automatic drive(input logic rr, input logic vv, input logic aa, input logic bb,
                       input logic e1, input logic e2, input string nm);
    #1;
    rst = rr; bus.v_in = vv; bus.a = aa; bus.b = bb;
    if (vv && !rr) reg_q.push_back('{e1, e2, nm});
    @(negedge clk);
  endtask

  // Hand-computed truth tables, indexed {a,b} and {a,b,cin}
  logic [3:0] ha_s = 4'b0110;
  logic [3:0] ha_c = 4'b1000;
  logic [7:0] fa_s = 8'b1001_0110;
  logic [7:0] fa_c = 8'b1110_1000;
`ifdef HALF_ADDER_A_STATS_EN
  logic [1:0] cnt_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif

  initial begin
    bus.a = 1'b0; bus.b = 1'b0; bus.v_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_y1_q", 16'(bus.y1_q), 16'd0);
    chk("reset_y2_q", 16'(bus.y2_q), 16'd0);
    chk("reset_v_q",  16'(bus.v_q),  16'd0);
`ifdef HALF_ADDER_A_STATS_EN
    chk("reset_cnt", 16'(bus.carry_cnt), 16'd0);
`endif

    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ab;
      ab = 2'(i);
      comb_vec(0, {3'b0, ab[1]}, {3'b0, ab[0]}, 1'b0,
               {3'b0, ha_s[i]}, {3'b0, ha_c[i]}, $sformatf("w1_ab%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] abc;
      abc = 3'(i);
      comb_vec(1, {3'b0, abc[2]}, {3'b0, abc[1]}, abc[0],
               {3'b0, fa_s[i]}, {3'b0, fa_c[i]}, $sformatf("fa_abc%0d", i));
    end

    comb_vec(2, 4'b1100, 4'b1010, 1'b0, 4'b0110, 4'b1000, "w4_c_a");
    comb_vec(2, 4'b1111, 4'b0101, 1'b0, 4'b1010, 4'b0101, "w4_f_5");
    comb_vec(2, 4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0000, "w4_0_f");

    @(negedge clk);
    drive(0, 1, 1, 1, 1'b0, 1'b1, "reg_11");
    drive(0, 0, 0, 1, 1'b0, 1'b0, "");
    chk("hold_v_q",  16'(bus.v_q),  16'd0);
    chk("hold_y1_q", 16'(bus.y1_q), 16'd0);
    chk("hold_y2_q", 16'(bus.y2_q), 16'd1);
    drive(0, 1, 1, 0, 1'b1, 1'b0, "reg_10");
    drive(0, 1, 0, 0, 1'b0, 1'b0, "reg_00");
    drive(0, 1, 0, 1, 1'b1, 1'b0, "reg_01");
    drive(0, 0, 1, 1, 1'b0, 1'b0, "");
    chk("hold2_y1_q", 16'(bus.y1_q), 16'd1);
    chk("hold2_y2_q", 16'(bus.y2_q), 16'd0);
    drive(1, 1, 1, 0, 1'b0, 1'b0, "");
    chk("rstwin_y1_q", 16'(bus.y1_q), 16'd0);
    chk("rstwin_y2_q", 16'(bus.y2_q), 16'd0);
    chk("rstwin_v_q",  16'(bus.v_q),  16'd0);
    drive(0, 1, 1, 1, 1'b0, 1'b1, "reg_first_after_rst");

`ifdef HALF_ADDER_A_STATS_EN
    drive(1, 0, 0, 0, 1'b0, 1'b0, "");
    chk("cnt_cleared", 16'(bus.carry_cnt), 16'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 1, 1'b0, 1'b1, $sformatf("cnt_reg_%0d", i));
      chk($sformatf("cnt_step%0d", i), 16'(bus.carry_cnt), 16'(cnt_exp[i]));
    end
    drive(1, 0, 0, 0, 1'b0, 1'b0, "");
    chk("cnt_after_rst", 16'(bus.carry_cnt), 16'd0);
`endif

    drive(0, 0, 0, 0, 1'b0, 1'b0, "");
    drive(0, 0, 0, 0, 1'b0, 1'b0, "");
    chk("reg_queue_drained", 16'(reg_q.size()), 16'd0);
    chk("comb_queue_drained", 16'(comb_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
